fifo_wr_arb: RTL and testbench

Round-robin write-port arbiter that shares one `sync_fifo` write port among NREQ producers. Each producer uses a valid/ready handshake. The arbiter grants one owner at a time for a bounded burst of up to QUANTUM beats, then rotates. Each accepted word is tagged with its source index so the consumer on the FIFO read side can demultiplex. The block sits directly in front of `sync_fifo` and drives its `wr_en`/`din` from the FIFO's `full` flag.

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/rr_pick.sv | 30 +++
 rtl/fifo_wr_arb.sv | 107 ++++++++++
 tb/tb_fifo_wr_arb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and limits for the round-robin FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  localparam int NREQ_MAX = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of mask scanning from start,
// wrapping modulo NREQ (which need not be a power of two).
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] mask,
  input  logic [IDW-1:0]  start,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  logic [IDW-1:0] w_cand;
  logic           w_hit;

  // Scan from the farthest candidate back to start so the nearest hit wins.
  always_comb begin
    found  = 1'b0;
    idx    = {IDW{1'b0}};
    w_cand = {IDW{1'b0}};
    w_hit  = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = IDW'((int'(start) + k) % NREQ);
      w_hit  = mask[w_cand];
      found  = found | w_hit;
      idx    = w_hit ? w_cand : idx;
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready producers,
// with bursts of up to QUANTUM beats per grant and {source id, payload} tagging.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int DWIDTH  = 16,
  parameter  int QUANTUM = 4,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [IDW+DWIDTH-1:0]  fifo_din,
  output logic                   grant_valid,
  output logic [IDW-1:0]         grant_id
);

  localparam int CW = $clog2(QUANTUM + 1);

  arb_state_t     r_state;
  logic [IDW-1:0] r_owner;
  logic [IDW-1:0] r_rr_ptr;
  logic [CW-1:0]  r_cnt;

  logic           w_own;
  logic           w_owner_valid;
  logic           w_ready;
  logic           w_accept;
  logic           w_release;
  logic           w_found;
  logic [IDW-1:0] w_nxt_ptr;
  logic [IDW-1:0] w_start;
  logic [IDW-1:0] w_pick;

  assign w_own         = (r_state == ARB_OWN);
  assign w_owner_valid = req_valid[r_owner];
  assign w_ready       = w_own & ~fifo_full;
  assign w_accept      = w_ready & w_owner_valid;
  assign w_release     = w_own & (~w_owner_valid | (w_accept & (r_cnt == CW'(QUANTUM - 1))));
  assign w_nxt_ptr     = (r_owner == IDW'(NREQ - 1)) ? {IDW{1'b0}} : r_owner + IDW'(1);

  // While owning, the only pick that matters is the release re-pick, which
  // starts just past the owner so the owner ends up with lowest priority.
  assign w_start = w_own ? w_nxt_ptr : r_rr_ptr;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .mask  (req_valid),
    .start (w_start),
    .found (w_found),
    .idx   (w_pick)
  );

  assign req_ready   = w_ready ? (NREQ'(1'b1) << r_owner) : {NREQ{1'b0}};
  assign fifo_wr_en  = w_accept;
  assign fifo_din    = {r_owner, req_data[r_owner*DWIDTH +: DWIDTH]};
  assign grant_valid = w_own;
  assign grant_id    = r_owner;

  // Arbitration state, owner, rotation pointer and burst beat counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ARB_IDLE;
      r_owner  <= {IDW{1'b0}};
      r_rr_ptr <= {IDW{1'b0}};
      r_cnt    <= {CW{1'b0}};
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_state <= ARB_OWN;
            r_owner <= w_pick;
            r_cnt   <= {CW{1'b0}};
          end else begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_OWN: begin
          if (w_release) begin
            r_rr_ptr <= w_nxt_ptr;
            r_cnt    <= {CW{1'b0}};
            if (w_found) begin
              r_owner <= w_pick;
            end else begin
              r_state <= ARB_IDLE;
            end
          end else if (w_accept) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_cnt <= r_cnt;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenarios plus a randomized phase,
// checked against a cycle-level reference model and a 7-word bench FIFO model.
module tb_fifo_wr_arb;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int Q   = 4;
  localparam int IDW = 2;
  localparam int FIFO_CAP = 7;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [N-1:0]        req_valid = '0;
  logic [N*DW-1:0]     req_data = '0;
  logic [N-1:0]        req_ready;
  logic                fifo_full = 1'b0;
  logic                fifo_wr_en;
  logic [IDW+DW-1:0]   fifo_din;
  logic                grant_valid;
  logic [IDW-1:0]      grant_id;

  logic                reset3 = 1'b1;
  logic [2:0]          req_valid3 = '0;
  logic [3*DW-1:0]     req_data3 = '0;
  logic [2:0]          req_ready3;
  logic                fifo_wr_en3;
  logic [IDW+DW-1:0]   fifo_din3;
  logic                grant_valid3;
  logic [IDW-1:0]      grant_id3;

  int checks = 0;
  int failures = 0;

  logic [N-1:0]      tv_valid = '0;
  logic [DW-1:0]     tv_data[N];
  bit                tv_rd = 1'b0;
  bit                tv_rand = 1'b0;
  logic [IDW+DW-1:0] fq[$];
  logic [IDW+DW-1:0] wlog[$];
  logic [IDW+DW-1:0] rlog[$];
  int m_own = 0, m_owner = 0, m_ptr = 0, m_cnt = 0;
  int n_wr = 0, n_rd = 0;
  int base;

  fifo_wr_arb #(.NREQ(N), .DWIDTH(DW), .QUANTUM(Q)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_din(fifo_din), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  fifo_wr_arb #(.NREQ(3), .DWIDTH(DW), .QUANTUM(Q)) dut3 (
    .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_data(req_data3),
    .req_ready(req_ready3), .fifo_full(1'b0), .fifo_wr_en(fifo_wr_en3),
    .fifo_din(fifo_din3), .grant_valid(grant_valid3), .grant_id(grant_id3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance model.
  task automatic tick();
    logic [N-1:0]      exp_rdy;
    logic [IDW+DW-1:0] word;
    int p, cur;
    bit acc, full_now, rel;
    req_valid = tv_valid;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = tv_data[i];
    full_now = (fq.size() >= FIFO_CAP);
    fifo_full = full_now;
    #1;
    cur = m_owner;
    acc = (m_own == 1) && !full_now && tv_valid[cur];
    exp_rdy = (m_own == 1 && !full_now) ? (4'b0001 << cur) : 4'b0000;
    word = {cur[IDW-1:0], tv_data[cur]};
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("fifo_wr_en", 32'(fifo_wr_en), 32'(acc));
    chk("grant_valid", 32'(grant_valid), 32'(m_own));
    if (m_own == 1) chk("grant_id", 32'(grant_id), 32'(cur));
    if (acc) begin
      chk("fifo_din", 32'(fifo_din), 32'(word));
      wlog.push_back(word);
    end
    if (tv_rd && fq.size() > 0) begin
      rlog.push_back(fq.pop_front());
      n_rd++;
    end
    if (acc) begin
      fq.push_back(word);
      n_wr++;
    end
    if (m_own == 0) begin
      p = pick(tv_valid, m_ptr);
      if (p >= 0) begin
        m_own = 1; m_owner = p; m_cnt = 0;
      end
    end else begin
      rel = !tv_valid[cur] || (acc && m_cnt == Q - 1);
      if (rel) begin
        m_ptr = (cur + 1) % N;
        p = pick(tv_valid, m_ptr);
        m_cnt = 0;
        if (p >= 0) m_owner = p;
        else m_own = 0;
      end else if (acc) begin
        m_cnt++;
      end
    end
    if (acc) tv_data[cur] = tv_rand ? 16'($urandom) : tv_data[cur] + 16'd1;
    @(posedge clk); #1;
  endtask

  // Assert reset between edges with inputs still applied; outputs must drop at once.
  task automatic reset_dut();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_gvalid", 32'(grant_valid), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_own = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    fq.delete(); wlog.delete(); rlog.delete();
    n_wr = 0; n_rd = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) tv_data[i] = 16'h0000;
    #1;
    chk("init_ready", 32'(req_ready), 32'd0);
    chk("init_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("init_gvalid", 32'(grant_valid), 32'd0);
    chk("init_gid", 32'(grant_id), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single requester 2 streams ten words with the FIFO drained continuously.
    tv_rd = 1'b1;
    tv_valid = 4'b0100;
    tv_data[2] = 16'hA000;
    for (int t = 0; t < 11; t++) tick();
    tv_valid = 4'b0000;
    tick();
    chk("single_count", 32'(wlog.size()), 32'd10);
    for (int k = 0; k < 10 && k < wlog.size(); k++)
      chk("single_word", 32'(wlog[k]), 32'({2'd2, 16'hA000 + 16'(k)}));

    // Fairness, with a reset mid-burst first so arbitration restarts at index 0.
    tv_valid = 4'b1111;
    tick();
    tick();
    reset_dut();
    for (int i = 0; i < N; i++) tv_data[i] = 16'(i * 16'h1000);
    for (int t = 0; t < 17; t++) tick();
    tv_valid = 4'b0000;
    for (int t = 0; t < 10; t++) tick();
    chk("fair_count", 32'(rlog.size() >= 16), 32'd1);
    for (int k = 0; k < 16 && k < rlog.size(); k++)
      chk("fair_tag", 32'(rlog[k][IDW+DW-1:DW]), 32'(k / 4));

    // Early release: req 1 drops valid after two beats while req 3 waits.
    reset_dut();
    tv_valid = 4'b0010;
    tick();
    tv_valid = 4'b1010;
    tick();
    tick();
    tv_valid = 4'b1000;
    tick();
    chk("early_gid3", 32'(grant_id), 32'd3);
    chk("early_rdy1", 32'(req_ready[1]), 32'd0);
    tv_valid = 4'b1010;
    for (int t = 0; t < 4; t++) tick();
    chk("early_back_to1", 32'(grant_id), 32'd1);
    tv_valid = 4'b0000;
    for (int t = 0; t < 3; t++) tick();

    // Backpressure: fill the FIFO during req 0's bursts, then release one slot.
    reset_dut();
    tv_rd = 1'b0;
    tv_valid = 4'b0001;
    for (int t = 0; t < 9; t++) tick();
    chk("bp_occupancy", 32'(fq.size()), 32'(FIFO_CAP));
    chk("bp_ready", 32'(req_ready), 32'd0);
    chk("bp_wr_en", 32'(fifo_wr_en), 32'd0);
    base = n_wr;
    tv_rd = 1'b1;
    tick();
    tv_rd = 1'b0;
    for (int t = 0; t < 3; t++) tick();
    chk("bp_one_beat", 32'(n_wr - base), 32'd1);
    tv_valid = 4'b0000;
    tv_rd = 1'b1;
    for (int t = 0; t < 10; t++) tick();
    chk("bp_wr_eq_rd", 32'(n_wr), 32'(n_rd));
    chk("bp_empty", 32'(fq.size()), 32'd0);

    // Randomized traffic with sticky valids and random draining.
    reset_dut();
    tv_rand = 1'b1;
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) tv_valid[i] = ~tv_valid[i];
      tv_rd = ($urandom_range(0, 1) == 1);
      tick();
    end
    tv_valid = 4'b0000;
    tv_rd = 1'b1;
    for (int t = 0; t < 12; t++) tick();
    chk("rand_wr_eq_rd", 32'(n_wr), 32'(n_rd));

    // Non-power-of-two instance: grants rotate 0,1,2,0 and wrap past 2 to 0.
    req_valid3 = 3'b111;
    req_data3 = {16'h2222, 16'h1111, 16'h0000};
    reset3 = 1'b0;
    for (int t = 0; t < 16; t++) begin
      @(posedge clk); #1;
      chk("np2_gvalid", 32'(grant_valid3), 32'd1);
      chk("np2_gid", 32'(grant_id3), 32'((t / 4) % 3));
      chk("np2_wr", 32'(fifo_wr_en3), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
